instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: value loaded into pc on reset.
REQ-002 Parameter MAX_WAIT, default 15: maximum number of no-ack fetch cycles before a fault is declared; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level request to execute instructions.
REQ-006 imem_req  output  1  instruction-memory fetch request.
REQ-007 imem_addr  output  32  fetch address; always equal to pc.
REQ-008 imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instruction  output  32  registered instruction presented to the datapath.
REQ-011 exec_valid  output  1  one-cycle strobe; the datapath commits the register write only when it is 1.
REQ-012 pc  output  32  current program counter.
REQ-013 halted  output  1  sequencer is stopped in HALT or FAULT.
REQ-014 fault  output  1  fetch timeout occurred.
REQ-015 retired  output  32  count of executed instructions.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, FETCH, EXEC, HALT and FAULT.
REQ-017 IDLE: outputs inactive; run=1 -> FETCH on the next edge; run=0 -> remain in IDLE.
REQ-018 FETCH: imem_req=1 and imem_addr=pc, held stable until the state is left; imem_ack=1 -> instruction<=imem_rdata and go to EXEC.
REQ-019 The wait counter SHALL clear on FETCH entry and increment each FETCH cycle with imem_ack=0; counter==MAX_WAIT with imem_ack=0 -> FAULT, so at most MAX_WAIT+1 request cycles occur.
REQ-020 EXEC: exec_valid=1 for exactly this cycle; pc<=pc+4 modulo 2^32, so 32'hFFFFFFFC wraps to 0.
REQ-021 Leaving EXEC: instruction[6:0]==7'b1110011 (SYSTEM) -> HALT, with pc still advanced; else run=1 -> FETCH; else -> IDLE.
REQ-022 A run deassert during FETCH SHALL NOT abort the fetch; the fetched instruction executes, then the FSM goes to IDLE.
REQ-023 HALT: halted=1, fault=0; the only exit is reset.
REQ-024 FAULT: halted=1, fault=1; pc holds the failing address; the only exit is reset.
REQ-025 imem_ack is ignored in every state other than FETCH.
REQ-026 Ack-to-strobe latency is one cycle: ack sampled at edge n gives exec_valid=1 in the cycle after edge n.
REQ-027 Back-to-back throughput with zero-wait memory is one instruction per 2 cycles.

Reset
REQ-028 Reset SHALL immediately force: state=IDLE, pc=RESET_PC, instruction=32'h00000013 (NOP), imem_req=0, exec_valid=0, halted=0, fault=0, retired=0, wait counter=0.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL drop imem_req and exec_valid asynchronously, without waiting for a clock edge.

Configuration
REQ-030 Macro SEQ_RETIRE_COUNTER_EN defined: retired increments by 1 (wrapping at 2^32) on each EXEC cycle, including the SYSTEM instruction.
REQ-031 Macro SEQ_RETIRE_COUNTER_EN undefined: retired is constant 32'h0 and no counter register is built.

Verification
REQ-032 Reset, run=1, zero-wait memory returning 32'h00500093 at addr 0 -> imem_req at addr 0, exec_valid 2 cycles after run, pc=4, instruction=32'h00500093.
REQ-033 Ack delayed 3 cycles at pc=8 -> imem_addr held at 8 for 4 cycles, exactly one exec_valid pulse, pc=12.
REQ-034 MAX_WAIT=15, no ack -> 16 request cycles, then fault=1, halted=1, pc unchanged, exec_valid never asserted; only reset recovers.
REQ-035 Word 32'h00000073 fetched at pc=20 -> one exec_valid pulse, then HALT with pc=24 and halted=1; run toggling has no effect.
REQ-036 RESET_PC=32'hFFFFFFFC, one instruction executed -> pc wraps to 0; run dropped during the following fetch -> that instruction executes, then IDLE.
REQ-037 Build with SEQ_RETIRE_COUNTER_EN, 5 instructions ending in ECALL -> retired=5; build without it -> retired=0 throughout.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Five-state fetch/execute sequencer: fetches one word per instruction, strobes exec_valid,
// and stops on SYSTEM opcodes (HALT) or fetch timeouts (FAULT). Define SEQ_RETIRE_COUNTER_EN to build the retire counter.
module instruction_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        exec_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        FAULT
    } seqState_t;

    localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP_WORD   = 32'h00000013;

    seqState_t   stateReg;
    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        reqReg;
    logic        execReg;
    logic        haltReg;
    logic        faultReg;
    logic [7:0]  waitCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            pcReg     <= RESET_PC;
            instrReg  <= NOP_WORD;
            reqReg    <= 1'b0;
            execReg   <= 1'b0;
            haltReg   <= 1'b0;
            faultReg  <= 1'b0;
            waitCount <= 8'd0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (run) begin
                        stateReg  <= FETCH;
                        reqReg    <= 1'b1;
                        waitCount <= 8'd0;
                    end
                end
                FETCH: begin
                    // run is deliberately not consulted here: a started fetch always completes.
                    if (imem_ack) begin
                        instrReg <= imem_rdata;
                        reqReg   <= 1'b0;
                        execReg  <= 1'b1;
                        stateReg <= EXEC;
                    end else if (waitCount == WAIT_LIMIT) begin
                        reqReg   <= 1'b0;
                        haltReg  <= 1'b1;
                        faultReg <= 1'b1;
                        stateReg <= FAULT;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                EXEC: begin
                    execReg <= 1'b0;
                    pcReg   <= pcReg + 32'd4;
                    if (instrReg[6:0] == OPC_SYSTEM) begin
                        haltReg  <= 1'b1;
                        stateReg <= HALT;
                    end else if (run) begin
                        reqReg    <= 1'b1;
                        waitCount <= 8'd0;
                        stateReg  <= FETCH;
                    end else begin
                        stateReg <= IDLE;
                    end
                end
                HALT, FAULT: begin
                    // Terminal states; only reset leaves them.
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = reqReg;
    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign instruction = instrReg;
    assign exec_valid  = execReg;
    assign halted      = haltReg;
    assign fault       = faultReg;

`ifdef SEQ_RETIRE_COUNTER_EN
    logic [31:0] retiredReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retiredReg <= 32'd0;
        end else if (stateReg == EXEC) begin
            retiredReg <= retiredReg + 32'd1;
        end
    end

    assign retired = retiredReg;
`else
    assign retired = 32'h00000000;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a cycle table for the main program flow plus
// hand sequences for reset-vector wrap, asynchronous reset and fetch timeout.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic        exec_valid;
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    logic        runB;
    logic        ackB;
    logic [31:0] rdataB;
    logic        reqB;
    logic [31:0] addrB;
    logic [31:0] instrB;
    logic        evB;
    logic [31:0] pcB;
    logic        haltedB;
    logic        faultB;
    logic [31:0] retiredB;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .exec_valid (exec_valid),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    instruction_sequencer #(.RESET_PC(32'hFFFFFFFC), .MAX_WAIT(15)) dutWrap (
        .clk        (clk),
        .reset      (reset),
        .run        (runB),
        .imem_req   (reqB),
        .imem_addr  (addrB),
        .imem_ack   (ackB),
        .imem_rdata (rdataB),
        .instruction(instrB),
        .exec_valid (evB),
        .pc         (pcB),
        .halted     (haltedB),
        .fault      (faultB),
        .retired    (retiredB)
    );

    typedef struct {
        logic        run;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic        ev;
        logic        hlt;
        logic        flt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic q, logic e,
                                logic h, logic f, logic [31:0] p, logic [31:0] i, logic [31:0] rt);
        vec_t v;
        v.run = r; v.ack = a; v.rdata = d; v.req = q; v.ev = e;
        v.hlt = h; v.flt = f; v.pc = p; v.instr = i; v.ret = rt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expRetired(input logic [31:0] cnt);
`ifdef SEQ_RETIRE_COUNTER_EN
        return cnt;
`else
        return 32'h0 & cnt;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int reqCycles;
        int evCycles;
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        runB = 1'b0; ackB = 1'b0; rdataB = 32'h0;

        //         run ack rdata         req ev hlt flt pc     instr          retired
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 32'd0,  32'h00000013, 0)); // idle holds
        vecs.push_back(mk(1, 1, 32'hDEADBEEF, 1, 0, 0, 0, 32'd0,  32'h00000013, 0)); // ack ignored in IDLE
        vecs.push_back(mk(1, 1, 32'h00500093, 0, 1, 0, 0, 32'd0,  32'h00500093, 0));
        vecs.push_back(mk(1, 1, 32'h11111111, 1, 0, 0, 0, 32'd4,  32'h00500093, 1)); // ack ignored in EXEC
        vecs.push_back(mk(1, 1, 32'h00100113, 0, 1, 0, 0, 32'd4,  32'h00100113, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd8,  32'h00100113, 2));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd8,  32'h00100113, 2));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd8,  32'h00100113, 2));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd8,  32'h00100113, 2));
        vecs.push_back(mk(1, 1, 32'h00208193, 0, 1, 0, 0, 32'd8,  32'h00208193, 2));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 32'd12, 32'h00208193, 3)); // run low -> IDLE
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd12, 32'h00208193, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 0, 32'd12, 32'h00208193, 3)); // run drop, fetch continues
        vecs.push_back(mk(0, 1, 32'h00308213, 0, 1, 0, 0, 32'd12, 32'h00308213, 3));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 32'd16, 32'h00308213, 4));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd16, 32'h00308213, 4));
        vecs.push_back(mk(1, 1, 32'h00000013, 0, 1, 0, 0, 32'd16, 32'h00000013, 4));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 32'd20, 32'h00000013, 5));
        vecs.push_back(mk(1, 1, 32'h00000073, 0, 1, 0, 0, 32'd20, 32'h00000073, 5)); // ECALL
        vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'd24, 32'h00000073, 6)); // HALT
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 0, 32'd24, 32'h00000073, 6));
        vecs.push_back(mk(1, 1, 32'h0,        0, 0, 1, 0, 32'd24, 32'h00000073, 6));

        #12;
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_pc", pc, 32'd0);
        check("reset_instr", instruction, 32'h00000013);
        check("reset_retired", retired, 32'd0);
        check("reset_halted", {30'b0, halted, fault}, 32'd0);
        check("reset_pcB", pcB, 32'hFFFFFFFC);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run = vecs[i].run; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            tick();
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_ev", i), {31'b0, exec_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_hf", i), {30'b0, halted, fault}, {30'b0, vecs[i].hlt, vecs[i].flt});
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc);
            check($sformatf("v%0d_instr", i), instruction, vecs[i].instr);
            check($sformatf("v%0d_ret", i), retired, expRetired(vecs[i].ret));
            $display("[TB] vec %0d run=%0b ack=%0b req=%0b ev=%0b pc=%h instr=%h", i,
                     run, imem_ack, imem_req, exec_valid, pc, instruction);
        end

        // Reset vector 0xFFFFFFFC wraps to 0; run dropped mid-fetch still executes.
        @(negedge clk); runB = 1'b1;
        tick(); check("wrap_fetch_req", {31'b0, reqB}, 32'd1); check("wrap_fetch_addr", addrB, 32'hFFFFFFFC);
        @(negedge clk); ackB = 1'b1; rdataB = 32'h00000013;
        tick(); check("wrap_exec", {31'b0, evB}, 32'd1);
        @(negedge clk); ackB = 1'b0;
        tick(); check("wrap_pc", pcB, 32'd0); check("wrap_addr", addrB, 32'd0); check("wrap_req", {31'b0, reqB}, 32'd1);
        @(negedge clk); runB = 1'b0;
        tick(); check("drop_fetch_req", {31'b0, reqB}, 32'd1);
        @(negedge clk); ackB = 1'b1; rdataB = 32'h00400093;
        tick(); check("drop_exec", {31'b0, evB}, 32'd1); check("drop_instr", instrB, 32'h00400093);
        @(negedge clk); ackB = 1'b0;
        tick(); check("drop_idle_pc", pcB, 32'd4); check("drop_idle_req", {31'b0, reqB}, 32'd0);
        tick(); check("drop_idle_hold", {30'b0, reqB, evB}, 32'd0);
        $display("[TB] wrap sequence pc=%h instr=%h", pcB, instrB);

        // Asynchronous reset drops imem_req mid-FETCH and exec_valid mid-EXEC.
        doReset();
        @(negedge clk); run = 1'b1; imem_ack = 1'b0;
        tick(); check("async_pre_req", {31'b0, imem_req}, 32'd1);
        #2; reset = 1'b1; #1;
        check("async_req_drop", {31'b0, imem_req}, 32'd0);
        @(negedge clk); reset = 1'b0;
        tick();
        @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h00500093;
        tick(); check("async_pre_ev", {31'b0, exec_valid}, 32'd1);
        #2; reset = 1'b1; #1;
        check("async_ev_drop", {31'b0, exec_valid}, 32'd0);
        check("async_instr", instruction, 32'h00000013);
        $display("[TB] async reset req=%0b ev=%0b", imem_req, exec_valid);

        // Fetch timeout: 16 request cycles, then FAULT.
        @(negedge clk); reset = 1'b0; run = 1'b1; imem_ack = 1'b0;
        reqCycles = 0; evCycles = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            reqCycles += imem_req ? 1 : 0;
            evCycles  += exec_valid ? 1 : 0;
        end
        check("timeout_req_cycles", reqCycles, 32'd16);
        check("timeout_no_exec", evCycles, 32'd0);
        check("timeout_hf", {30'b0, halted, fault}, 32'd3);
        check("timeout_pc", pc, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); run = c[0]; imem_ack = 1'b1; imem_rdata = 32'h00000013;
            tick();
        end
        check("fault_sticky", {30'b0, halted, fault}, 32'd3);
        check("fault_req_low", {31'b0, imem_req}, 32'd0);
        $display("[TB] timeout req_cycles=%0d fault=%0b", reqCycles, fault);
        doReset();
        #1;
        check("fault_recover", {30'b0, halted, fault}, 32'd0);
        check("fault_recover_ret", retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
